// File: rtl/load_store_execute_unit_pkg.sv
// Shared types for the load/store execute path: scheduler entry layout,
// memory action/size encodings and the execute FSM state set.
package load_store_execute_unit_pkg;

  localparam int PHYS_REG_COUNT = 64;
  localparam int PREG_W         = $clog2(PHYS_REG_COUNT);

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_action_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] pc;
    mem_action_e mem_action;
    mem_size_e   mem_size;
    logic        mem_signed;
  } entry_meta_t;

  typedef struct packed {
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [PREG_W-1:0] dst;
    logic [15:0]       imm;
    entry_meta_t       meta;
  } scheduler_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/load_store_execute_unit_align.sv
// Lane steering for D-cache traffic: store byte enables / replicated write
// data, and load lane extraction with zero or sign extension.
module load_store_execute_unit_align
  import load_store_execute_unit_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = i_rdata >> {i_addr_lo, 3'b000};
    o_byte_en   = 4'hF;
    o_wdata     = i_store_data;
    o_load_data = shifted;
    case (i_size)
      MEM_BYTE: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{i_signed & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        o_byte_en   = 4'b0011 << i_addr_lo;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{i_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Word accesses are only issued aligned, so the shift is zero here.
        o_byte_en   = 4'hF;
        o_wdata     = i_store_data;
        o_load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_execute_unit.sv
// Single-outstanding load/store execute unit: takes one entry from the
// load-store queue, issues one D-cache access and reports completion.
module load_store_execute_unit
  import load_store_execute_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_want_to_execute,
  input  scheduler_entry_t      i_entry,
  output logic                  o_take,
  output logic [PREG_W-1:0]     o_src1_addr,
  output logic [PREG_W-1:0]     o_src2_addr,
  input  logic [31:0]           i_src1_value,
  input  logic [31:0]           i_src2_value,
  output logic                  o_mem_req_valid,
  output logic                  o_mem_req_write,
  output logic [31:0]           o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_byte_en,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_resp_valid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_wb_valid,
  output logic [PREG_W-1:0]     o_wb_dst,
  output logic [31:0]           o_wb_data,
  output logic                  o_done_valid,
  output logic [31:0]           o_done_pc,
  output logic                  o_exception
);

  lsu_state_e        state_q, state_d;
  logic [PREG_W-1:0] dst_q, dst_d;
  logic [31:0]       pc_q, pc_d;
  mem_action_e       action_q, action_d;
  mem_size_e         size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       store_data_q, store_data_d;
  logic              exc_q, exc_d;
  logic [31:0]       load_data_q, load_data_d;

  logic        take;
  logic [31:0] take_addr;
  logic        take_misaligned;
  logic [3:0]  align_byte_en;
  logic [31:0] align_wdata;
  logic [31:0] align_load_data;

  load_store_execute_unit_align u_align (
    .i_size       (size_q),
    .i_addr_lo    (addr_q[1:0]),
    .i_signed     (signed_q),
    .i_store_data (store_data_q),
    .i_rdata      (i_mem_rdata),
    .o_byte_en    (align_byte_en),
    .o_wdata      (align_wdata),
    .o_load_data  (align_load_data)
  );

  always_comb begin
    take            = (state_q == ST_IDLE) && i_want_to_execute && !i_flush;
    take_addr       = i_src1_value + {{16{i_entry.imm[15]}}, i_entry.imm};
    take_misaligned = ((i_entry.meta.mem_size == MEM_HALF) && take_addr[0]) ||
                      ((i_entry.meta.mem_size == MEM_WORD) && (take_addr[1:0] != 2'b00));

    state_d      = state_q;
    dst_d        = dst_q;
    pc_d         = pc_q;
    action_d     = action_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    exc_d        = exc_q;
    load_data_d  = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          dst_d        = i_entry.dst;
          pc_d         = i_entry.meta.pc;
          action_d     = i_entry.meta.mem_action;
          size_d       = i_entry.meta.mem_size;
          signed_d     = i_entry.meta.mem_signed;
          addr_d       = take_addr;
          store_data_d = i_src2_value;
          exc_d        = take_misaligned;
          load_data_d  = 32'd0;
          state_d      = take_misaligned ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // An accepted request owes us a response, so a flush must drain it.
        if (i_flush)              state_d = i_mem_req_ready ? ST_DRAIN : ST_IDLE;
        else if (i_mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_flush) begin
          state_d = i_mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (i_mem_resp_valid) begin
          state_d = ST_DONE;
          if (action_q == MEM_READ) load_data_d = align_load_data;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: if (i_mem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dst_q        <= '0;
      pc_q         <= '0;
      action_q     <= MEM_READ;
      size_q       <= MEM_BYTE;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      store_data_q <= '0;
      exc_q        <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      pc_q         <= pc_d;
      action_q     <= action_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      exc_q        <= exc_d;
      load_data_q  <= load_data_d;
    end
  end

  // Pass-through outputs are gated by rst so every output is 0 during reset.
  assign o_take      = take && !rst;
  assign o_src1_addr = rst ? '0 : i_entry.src1;
  assign o_src2_addr = rst ? '0 : i_entry.src2;

  assign o_mem_req_valid = (state_q == ST_REQ);
  assign o_mem_req_write = o_mem_req_valid && (action_q == MEM_WRITE);
  assign o_mem_addr      = o_mem_req_valid ? addr_q        : 32'd0;
  assign o_mem_wdata     = o_mem_req_valid ? align_wdata   : 32'd0;
  assign o_mem_byte_en   = o_mem_req_valid ? align_byte_en : 4'd0;

  assign o_done_valid = (state_q == ST_DONE) && !i_flush;
  assign o_done_pc    = o_done_valid ? pc_q : 32'd0;
  assign o_exception  = o_done_valid && exc_q;
  assign o_wb_valid   = o_done_valid && !exc_q && (action_q == MEM_READ);
  assign o_wb_dst     = o_wb_valid ? dst_q : '0;
  assign o_wb_data    = o_wb_valid ? load_data_q : 32'd0;

endmodule

// File: doc/load_store_execute_unit.md
LOAD_STORE_EXECUTE_UNIT -- requirements
Module: load_store_execute_unit

Interface
REQ-001 Parameter: none; widths come from the shared package (PHYS_REG_COUNT, scheduler_entry_t).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 i_flush  in  1  hazard-controller flush.
REQ-005 i_want_to_execute  in  1  load-store queue offers an entry.
REQ-006 i_entry  in  scheduler_entry_t  offered entry: src1, src2, dst, imm[15:0], meta.pc, meta.mem_action (READ/WRITE), meta.mem_size (BYTE/HALF/WORD), meta.mem_signed.
REQ-007 o_take  out  1  entry accepted this cycle (drives the queue's i_take).
REQ-008 o_src1_addr, o_src2_addr  out  $clog2(PHYS_REG_COUNT)  register-file read addresses = i_entry.src1/src2, combinational.
REQ-009 i_src1_value, i_src2_value  in  32  register-file read data, same cycle.
REQ-010 o_mem_req_valid  out  1; o_mem_req_write  out  1; o_mem_addr  out  32; o_mem_wdata  out  32; o_mem_byte_en  out  4  D-cache request.
REQ-011 i_mem_req_ready  in  1; i_mem_resp_valid  in  1; i_mem_rdata  in  32  D-cache handshake/response (word-aligned data).
REQ-012 o_wb_valid  out  1; o_wb_dst  out  $clog2(PHYS_REG_COUNT); o_wb_data  out  32  load writeback and register-valid set.
REQ-013 o_done_valid  out  1; o_done_pc  out  32; o_exception  out  1  completion to commit.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, DONE, DRAIN; one memory operation in flight at most.
REQ-015 o_take = (state==IDLE) && i_want_to_execute && !i_flush; on take, capture entry, src2 value and address = i_src1_value + sign-extended imm (32-bit wrap).
REQ-016 On take: misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0) -> DONE with exception latched; otherwise -> REQ.
REQ-017 REQ: o_mem_req_valid=1, address/byte_en/wdata held stable; byte_en BYTE=1<<addr[1:0], HALF=3<<addr[1:0], WORD=4'hF; wdata = store data replicated to the selected lanes; on i_mem_req_ready -> WAIT.
REQ-018 WAIT: on i_mem_resp_valid -> DONE; loads latch extracted data: lane selected by addr[1:0], zero- or sign-extended per meta.mem_signed; stores ignore rdata.
REQ-019 DONE: single cycle; o_done_valid=1, o_done_pc=captured pc, o_exception as latched; o_wb_valid=1 only for non-excepting loads; -> IDLE. No new take is allowed in DONE (one bubble per op).
REQ-020 Minimum latency take->done: 3 cycles (ready and response each arriving in the first cycle they are possible).
REQ-021 Flush in IDLE or DONE -> IDLE; DONE outputs are suppressed in a flush cycle.
REQ-022 Flush in REQ with i_mem_req_ready=0 -> IDLE (request withdrawn); with i_mem_req_ready=1 -> DRAIN.
REQ-023 Flush in WAIT -> DRAIN; if i_mem_resp_valid is asserted the same cycle -> IDLE.
REQ-024 DRAIN: no outputs asserted, o_take=0; on i_mem_resp_valid -> IDLE; further flushes stay in DRAIN.
REQ-025 i_mem_resp_valid outside WAIT/DRAIN is ignored.

Reset
REQ-026 rst asserted forces state=IDLE, clears all captured registers, and drives every output to 0 immediately, regardless of clk.
REQ-027 Reset mid-operation abandons any outstanding response; the D-cache is reset by the same rst.

Structure
REQ-028 scheduler_entry_t, mem_action/mem_size enums, PHYS_REG_COUNT and the FSM state enum live in the shared package.
REQ-029 One sub-module: load_store_align (combinational byte_en/wdata lane steering and load extract/extension).

Verification
REQ-030 Word load, src1=0x1000, imm=0x0004, ready and response immediate, rdata=0xDEADBEEF -> addr 0x1004, byte_en F, wb_data 0xDEADBEEF at take+3.
REQ-031 Signed byte load at addr 0x1003, rdata=0x80000000 -> byte_en 8, wb_data 0xFFFFFF80; unsigned variant -> 0x00000080.
REQ-032 Half store of 0x1234ABCD to 0x2002 -> byte_en C, wdata[31:16]=0xABCD, o_wb_valid=0, o_done_valid=1.
REQ-033 Word load at 0x1002 -> no mem request, o_exception=1 with o_done_valid at take+1, no writeback.
REQ-034 Flush in WAIT, response two cycles later -> DRAIN absorbs response, no done/wb, o_take=0 until IDLE.
REQ-035 rst pulsed mid-REQ without a clock edge -> o_mem_req_valid falls immediately, state IDLE after release.
